// File: rtl/rsa_modexp_core.sv
// Modular exponentiation result = m^e mod p using bit-serial Montgomery multiplication.
// Define RSA_CONST_TIME_EN to always run MUL so latency does not depend on e.
module rsa_modexp_core #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [EXP_W-1:0] e,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int SW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, PRE_M, PRE_X, SQR, MUL, POST, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] p_q, m_q, r2_q, x_q, mbar_q;
    logic [EXP_W-1:0] e_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    s;

    logic [WIDTH-1:0] mm_a, mm_b, mm_out;
    logic [SW-1:0]    s_add, s_odd, s_step, s_red;
    logic             a_bit, e_bit, mm_last, last_bit, operand_bad;

    // Operand routing for the single shared Montgomery multiplier.
    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state)
            PRE_M: begin mm_a = m_q;           mm_b = r2_q;          end
            PRE_X: begin mm_a = WIDTH'(1);     mm_b = r2_q;          end
            SQR:   begin mm_a = x_q;           mm_b = x_q;           end
            MUL:   begin mm_a = mbar_q;        mm_b = x_q;           end
            POST:  begin mm_a = x_q;           mm_b = WIDTH'(1);     end
            default: begin mm_a = '0;          mm_b = '0;            end
        endcase
    end

    always_comb begin
        a_bit = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (cnt == CW'(k)) a_bit = mm_a[k];
        end
        e_bit = 1'b0;
        for (int k = 0; k < EXP_W; k++) begin
            if (idx == IW'(k)) e_bit = e_q[k];
        end
    end

    // S stays below 2p between steps, so S + B + p < 4p fits in WIDTH+2 bits.
    assign s_add       = s + (a_bit ? SW'(mm_b) : '0);
    assign s_odd       = s_add + (s_add[0] ? SW'(p_q) : '0);
    assign s_step      = s_odd >> 1;
    assign s_red       = (s >= SW'(p_q)) ? (s - SW'(p_q)) : s;
    assign mm_out      = WIDTH'(s_red);
    assign mm_last     = (cnt == CW'(WIDTH));
    assign last_bit    = (idx == '0);
    assign operand_bad = !p_q[0] || (p_q <= WIDTH'(1)) || (m_q >= p_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            p_q    <= '0;
            m_q    <= '0;
            r2_q   <= '0;
            e_q    <= '0;
            x_q    <= '0;
            mbar_q <= '0;
            idx    <= '0;
            cnt    <= '0;
            s      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_q   <= p;
                        e_q   <= e;
                        m_q   <= m;
                        r2_q  <= r2;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    s   <= '0;
                    if (operand_bad) begin
                        err    <= 1'b1;
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        err   <= 1'b0;
                        idx   <= IW'(EXP_W - 1);
                        state <= PRE_M;
                    end
                end
                PRE_M, PRE_X, SQR, MUL, POST: begin
                    if (!mm_last) begin
                        s   <= s_step;
                        cnt <= cnt + CW'(1);
                    end else begin
                        s   <= '0;
                        cnt <= '0;
                        case (state)
                            PRE_M: begin
                                mbar_q <= mm_out;
                                state  <= PRE_X;
                            end
                            PRE_X: begin
                                x_q   <= mm_out;
                                state <= SQR;
                            end
                            SQR: begin
                                x_q <= mm_out;
`ifdef RSA_CONST_TIME_EN
                                state <= MUL;
`else
                                if (e_bit) begin
                                    state <= MUL;
                                end else if (last_bit) begin
                                    state <= POST;
                                end else begin
                                    idx   <= idx - IW'(1);
                                    state <= SQR;
                                end
`endif
                            end
                            MUL: begin
`ifdef RSA_CONST_TIME_EN
                                // Product for a zero exponent bit is computed but thrown away.
                                if (e_bit) x_q <= mm_out;
`else
                                x_q <= mm_out;
`endif
                                if (last_bit) begin
                                    state <= POST;
                                end else begin
                                    idx   <= idx - IW'(1);
                                    state <= SQR;
                                end
                            end
                            default: begin
                                result <= mm_out;
                                done   <= 1'b1;
                                state  <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Randomised self-checking bench for rsa_modexp_core against a plain-arithmetic modexp model.
module tb_rsa_modexp_core;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] p, e, m, r2;
    logic       busy, done, err;
    logic [7:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    rsa_modexp_core #(.WIDTH(8), .EXP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p(p), .e(e), .m(m), .r2(r2),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_modexp(input logic [7:0] bm, input logic [7:0] be, input logic [7:0] bp);
        longint r;
        r = 1 % longint'(bp);
        for (int k = 0; k < int'(be); k++) r = (r * longint'(bm)) % longint'(bp);
        return 8'(r);
    endfunction

    function automatic logic [7:0] ref_r2(input logic [7:0] bp);
        return 8'(65536 % int'(bp));
    endfunction

    function automatic int ref_nmul(input logic [7:0] be);
`ifdef RSA_CONST_TIME_EN
        return 3 + 2 * 8;
`else
        return 3 + 8 + $countones(be);
`endif
    endfunction

    // Entered and left at a negedge; the next start after return lands in the IDLE cycle after DONE.
    task automatic run_job(input logic [7:0] tp, input logic [7:0] te, input logic [7:0] tm,
                           input logic [7:0] tr2, input bit noise, input string tag);
        int k;
        int dc0;
        int exp_lat;
        bit exp_err;
        bit seen;
        logic [7:0] want;
        exp_err = (tp[0] == 1'b0) || (tp <= 8'd1) || (tm >= tp);
        exp_q.push_back(exp_err ? 8'd0 : ref_modexp(tm, te, tp));
        exp_lat = exp_err ? 1 : 1 + ref_nmul(te) * 9;
        dc0 = done_cnt;
        p = tp; e = te; m = tm; r2 = tr2; start = 1'b1;
        @(posedge clk);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 5000) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    p = 8'($urandom); e = 8'($urandom); m = 8'($urandom); r2 = 8'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                k++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        want = exp_q.pop_front();
        if (seen) begin
            check({tag, "_result"}, 32'(result), 32'(want));
            check({tag, "_err"}, 32'(err), 32'(exp_err));
            check({tag, "_latency"}, 32'(k), 32'(exp_lat));
            check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        end
        if (noise) begin
            start = 1'b1;
            p = 8'($urandom); e = 8'($urandom); m = 8'($urandom); r2 = 8'($urandom);
        end else begin
            start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        int dc0;
        logic [7:0] rp, rm, re;
        rst_n = 1'b0; start = 1'b0;
        p = '0; e = '0; m = '0; r2 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(8'd187, 8'd7,  8'd88, 8'd86, 1'b0, "rsa_enc");
        run_job(8'd187, 8'd23, 8'd11, 8'd86, 1'b0, "rsa_dec");
        run_job(8'd187, 8'd0,  8'd5,  8'd86, 1'b0, "e_zero");
        run_job(8'd187, 8'd3,  8'd0,  8'd86, 1'b0, "m_zero");
        run_job(8'd187, 8'd0,  8'd0,  8'd86, 1'b0, "m_e_zero");
        run_job(8'd186, 8'd7,  8'd5,  8'd86, 1'b0, "p_even");
        run_job(8'd187, 8'd7,  8'd200, 8'd86, 1'b0, "m_ge_p");
        run_job(8'd1,   8'd7,  8'd0,  8'd0,  1'b0, "p_one");
        run_job(8'd187, 8'd7,  8'd88, 8'd86, 1'b0, "err_clear");
        run_job(8'd187, 8'd7,  8'd88, 8'd86, 1'b1, "start_noise");
        run_job(8'd187, 8'd255, 8'd186, 8'd86, 1'b0, "e_all_ones");

        // Abort mid-SQR: result from the previous job must clear with no done pulse.
        run_job(8'd187, 8'd7, 8'd88, 8'd86, 1'b0, "pre_abort");
        dc0 = done_cnt;
        p = 8'd187; e = 8'd7; m = 8'd88; r2 = 8'd86; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_job(8'd187, 8'd7, 8'd88, 8'd86, 1'b0, "after_abort");

        for (int n = 0; n < 300; n++) begin
            rp = 8'(2 * $urandom_range(1, 127) + 1);
            rm = 8'($urandom_range(0, int'(rp) - 1));
            re = 8'($urandom_range(0, 255));
            run_job(rp, re, rm, ref_r2(rp), 1'b0, "rand");
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
